// File: rtl/serial_pkg.sv
// Shared helpers for the serial N-to-1 serializer.
package serial_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Slot-counter and word widths derived from the serializer geometry.
    function automatic int cnt_w(input int csnum);
        return clog2(csnum);
    endfunction

    function automatic int wsize(input int ssize, input int csnum);
        return ssize * csnum;
    endfunction

endpackage

// File: rtl/serial_sync_word_fifo.sv
// Single-clock word FIFO with show-ahead head, full/empty and occupancy count.
module sync_word_fifo
    import serial_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [DSIZE-1:0]        din,
    output logic                    full,
    output logic [clog2(DEPTH):0]   count,
    input  logic                    pop,
    output logic [DSIZE-1:0]        dout,
    output logic                    empty
);
    localparam int AW = clog2(DEPTH);

    logic [DSIZE-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wp;
    logic [AW:0]      r_rp;
    logic             w_push;
    logic             w_pop;

    // Extra pointer MSB separates full from empty when the low bits match.
    assign count  = r_wp - r_rp;
    assign empty  = (r_wp == r_rp);
    assign full   = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign dout   = r_mem[r_rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp[AW-1:0]] <= din;
    end

endmodule

// File: rtl/serial.sv
// N-to-1 serializer: word FIFO feeding a slot shifter, SSIZE bits per read.
// Define SERIAL_LSB_FIRST_EN to emit slots LSB-first instead of MSB-first.
module serial
    import serial_pkg::*;
#(
    parameter int SSIZE     = 1,
    parameter int CSNUM     = 8,
    parameter int DEPTH     = 4,
    parameter int DEF_VALUE = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [SSIZE*CSNUM-1:0]  wr_data,
    output logic                    wr_full,
    output logic [clog2(DEPTH):0]   wr_count,
    input  logic                    rd_en,
    output logic                    rd_vld,
    output logic [SSIZE-1:0]        rd_data,
    output logic                    rd_last,
    output logic                    rd_empty
);
    localparam int WSIZE = wsize(SSIZE, CSNUM);
    localparam int CNT_W = cnt_w(CSNUM);

    logic [WSIZE-1:0] r_shift;
    logic             r_shift_vld;
    logic [CNT_W-1:0] r_cnt;
    logic             r_vld;
    logic             r_last;
    logic [SSIZE-1:0] r_data;

    logic [WSIZE-1:0] w_head;
    logic [WSIZE-1:0] w_shift_nxt;
    logic [SSIZE-1:0] w_slot;
    logic             w_fifo_empty;
    logic             w_last;
    logic             w_rd_acc;
    logic             w_load;

    sync_word_fifo #(
        .DSIZE (WSIZE),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_en),
        .din   (wr_data),
        .full  (wr_full),
        .count (wr_count),
        .pop   (w_load),
        .dout  (w_head),
        .empty (w_fifo_empty)
    );

`ifdef SERIAL_LSB_FIRST_EN
    assign w_slot      = r_shift[SSIZE-1:0];
    assign w_shift_nxt = {{SSIZE{1'b0}}, r_shift[WSIZE-1:SSIZE]};
`else
    assign w_slot      = r_shift[WSIZE-1 -: SSIZE];
    assign w_shift_nxt = {r_shift[WSIZE-SSIZE-1:0], {SSIZE{1'b0}}};
`endif

    // A non-empty FIFO with an idle shifter always loads on the next edge,
    // so slots are only offered once they sit in the shifter.
    assign rd_empty = ~r_shift_vld;
    assign w_last   = (r_cnt == CNT_W'(CSNUM - 1));
    assign w_rd_acc = rd_en & r_shift_vld;
    assign w_load   = (~r_shift_vld | (w_rd_acc & w_last)) & ~w_fifo_empty;

    assign rd_vld  = r_vld;
    assign rd_last = r_last;
    assign rd_data = r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift     <= '0;
            r_shift_vld <= 1'b0;
            r_cnt       <= '0;
            r_vld       <= 1'b0;
            r_last      <= 1'b0;
            r_data      <= SSIZE'(DEF_VALUE);
        end else begin
            r_vld  <= w_rd_acc;
            r_last <= w_rd_acc & w_last;
            if (w_rd_acc) r_data <= w_slot;
            // Reloading on the final slot keeps consecutive words bubble-free.
            if (w_load) begin
                r_shift     <= w_head;
                r_shift_vld <= 1'b1;
                r_cnt       <= '0;
            end else if (w_rd_acc) begin
                r_shift <= w_shift_nxt;
                r_cnt   <= r_cnt + 1'b1;
                if (w_last) r_shift_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial.sv
// Self-checking bench for serial: directed scenarios plus a randomized stream.
module tb_serial;
    localparam int DP = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en, rd_en, wr_full, rd_vld, rd_last, rd_empty;
    logic [7:0] wr_data;
    logic [2:0] wr_count;
    logic [0:0] rd_data;

    logic       wr4_en, rd4_en, wr4_full, rd4_vld, rd4_last, rd4_empty;
    logic [7:0] wr4_data;
    logic [2:0] wr4_count;
    logic [3:0] rd4_data;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] wq[$];
    int got_d[$], got_l[$], got_c[$];

    always #5 clk = ~clk;

    serial #(.SSIZE(1), .CSNUM(8), .DEPTH(DP), .DEF_VALUE(0)) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
        .wr_count(wr_count), .rd_en(rd_en), .rd_vld(rd_vld), .rd_data(rd_data),
        .rd_last(rd_last), .rd_empty(rd_empty)
    );

    serial #(.SSIZE(4), .CSNUM(2), .DEPTH(DP), .DEF_VALUE(0)) u_dut4 (
        .clk(clk), .rst(rst), .wr_en(wr4_en), .wr_data(wr4_data), .wr_full(wr4_full),
        .wr_count(wr4_count), .rd_en(rd4_en), .rd_vld(rd4_vld), .rd_data(rd4_data),
        .rd_last(rd4_last), .rd_empty(rd4_empty)
    );

    // Reference slot extraction straight from the word value.
    function automatic int slot_of(input int w, input int k, input int ss, input int cs);
        int sh;
`ifdef SERIAL_LSB_FIRST_EN
        sh = ss * k;
`else
        sh = ss * (cs - 1 - k);
`endif
        return (w >> sh) & ((1 << ss) - 1);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        wr4_en = 1'b0; rd4_en = 1'b0; wr4_data = '0;
        tick; tick;
        rst = 1'b0;
    endtask

    // Writes wq on consecutive cycles and records every rd_vld slot with its cycle index.
    task automatic run(input int maxc);
        int idle, wi;
        idle = 0; wi = 0;
        got_d.delete(); got_l.delete(); got_c.delete();
        if (wq.size() > 0) begin wr_en = 1'b1; wr_data = wq[0]; wi = 1; end
        for (int c = 1; c <= maxc; c++) begin
            tick;
            if (wi < wq.size()) begin wr_data = wq[wi]; wi++; end
            else wr_en = 1'b0;
            if (rd_vld) begin
                got_d.push_back(int'(rd_data)); got_l.push_back(int'(rd_last)); got_c.push_back(c);
                idle = 0;
            end else if (got_d.size() > 0) idle++;
            if (idle >= 6) break;
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        n_vec++; if (rd_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld got %b exp 0", rd_vld); end
        n_vec++; if (rd_last !== 1'b0) begin n_err++; $display("FAIL reset_last got %b exp 0", rd_last); end
        n_vec++; if (rd_data !== 1'b0) begin n_err++; $display("FAIL reset_data got %h exp 0", rd_data); end
        n_vec++; if (wr_full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b exp 0", wr_full); end
        n_vec++; if (wr_count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", wr_count); end
        n_vec++; if (rd_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b exp 1", rd_empty); end
        n_vec++; if (rd4_empty !== 1'b1 || rd4_data !== 4'h0) begin
            n_err++; $display("FAIL reset_quad got empty=%b data=%h exp 1/0", rd4_empty, rd4_data);
        end
    endtask

    task automatic test_single;
        do_reset;
        rd_en = 1'b1;
        wq = '{8'hA5};
        run(40);
        n_vec++;
        if (got_d.size() != 8) begin
            n_err++; $display("FAIL single_len got %0d exp 8", got_d.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                n_vec++;
                if (got_d[k] != slot_of(8'hA5, k, 1, 8) || got_l[k] != int'(k == 7) || got_c[k] != 3 + k) begin
                    n_err++;
                    $display("FAIL single_slot%0d got d=%0d l=%0d c=%0d exp d=%0d l=%0d c=%0d", k,
                             got_d[k], got_l[k], got_c[k], slot_of(8'hA5, k, 1, 8), int'(k == 7), 3 + k);
                end
            end
        end
        n_vec++;
        if (rd_vld !== 1'b0 || rd_data !== 1'(slot_of(8'hA5, 7, 1, 8))) begin
            n_err++; $display("FAIL single_hold got vld=%b d=%b exp 0/%0d", rd_vld, rd_data, slot_of(8'hA5, 7, 1, 8));
        end
    endtask

    task automatic test_back_to_back;
        int w;
        do_reset;
        rd_en = 1'b1;
        wq = '{8'h12, 8'h34};
        run(60);
        n_vec++;
        if (got_d.size() != 16) begin
            n_err++; $display("FAIL b2b_len got %0d exp 16", got_d.size());
        end else begin
            for (int k = 0; k < 16; k++) begin
                w = (k < 8) ? 8'h12 : 8'h34;
                n_vec++;
                if (got_d[k] != slot_of(w, k % 8, 1, 8) || got_l[k] != int'(k % 8 == 7) || got_c[k] != 3 + k) begin
                    n_err++;
                    $display("FAIL b2b_slot%0d got d=%0d l=%0d c=%0d exp d=%0d l=%0d c=%0d", k,
                             got_d[k], got_l[k], got_c[k], slot_of(w, k % 8, 1, 8), int'(k % 8 == 7), 3 + k);
                end
            end
        end
    endtask

    task automatic test_full;
        logic [7:0] words[5];
        int ok;
        do_reset;
        for (int i = 0; i < 5; i++) begin
            words[i] = 8'((i * 37 + 11) ^ $urandom_range(0, 255));
            wr_en = 1'b1; wr_data = words[i];
            tick;
        end
        wr_en = 1'b0;
        n_vec++; if (wr_full !== 1'b1) begin n_err++; $display("FAIL full_flag got %b exp 1", wr_full); end
        n_vec++; if (wr_count !== 3'd4) begin n_err++; $display("FAIL full_count got %0d exp 4", wr_count); end
        n_vec++; if (rd_empty !== 1'b0) begin n_err++; $display("FAIL full_empty got %b exp 0", rd_empty); end
        wr_en = 1'b1; wr_data = 8'hEE;
        tick;
        wr_en = 1'b0;
        n_vec++; if (wr_count !== 3'd4 || wr_full !== 1'b1) begin
            n_err++; $display("FAIL full_reject got count=%0d full=%b exp 4/1", wr_count, wr_full);
        end
        rd_en = 1'b1;
        wq.delete();
        run(300);
        n_vec++;
        if (got_d.size() != 40) begin
            n_err++; $display("FAIL full_drain_len got %0d exp 40", got_d.size());
        end else begin
            ok = 1;
            for (int k = 0; k < 40; k++)
                if (got_d[k] != slot_of(words[k / 8], k % 8, 1, 8) || got_l[k] != int'(k % 8 == 7)) ok = 0;
            if (ok == 0) begin n_err++; $display("FAIL full_drain_data got corrupted stream exp 5 written words"); end
        end
        n_vec++; if (rd_empty !== 1'b1 || wr_count !== 3'd0) begin
            n_err++; $display("FAIL full_after got empty=%b count=%0d exp 1/0", rd_empty, wr_count);
        end
    endtask

    task automatic test_quad;
        int d[$], l[$];
        do_reset;
        wr4_en = 1'b1; wr4_data = 8'h3C; rd4_en = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick;
            wr4_en = 1'b0;
            if (rd4_vld) begin d.push_back(int'(rd4_data)); l.push_back(int'(rd4_last)); end
        end
        rd4_en = 1'b0;
        n_vec++;
        if (d.size() != 2) begin
            n_err++; $display("FAIL quad_len got %0d exp 2", d.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                n_vec++;
                if (d[k] != slot_of(8'h3C, k, 4, 2) || l[k] != int'(k == 1)) begin
                    n_err++; $display("FAIL quad_slot%0d got d=%h l=%0d exp d=%h l=%0d", k, d[k], l[k],
                                      slot_of(8'h3C, k, 4, 2), int'(k == 1));
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        int seen, guard;
        do_reset;
        rd_en = 1'b1; wr_en = 1'b1; wr_data = 8'hFF;
        tick;
        wr_en = 1'b0;
        seen = 0; guard = 0;
        while (seen < 3 && guard < 20) begin
            if (rd_vld) seen++;
            if (seen < 3) begin tick; guard++; end
        end
        n_vec++; if (seen != 3) begin n_err++; $display("FAIL midrst_wait got %0d slots exp 3", seen); end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_vec++; if (rd_vld !== 1'b0 || rd_empty !== 1'b1 || wr_count !== 3'd0 || rd_last !== 1'b0) begin
            n_err++; $display("FAIL midrst_state got vld=%b empty=%b count=%0d last=%b exp 0/1/0/0",
                              rd_vld, rd_empty, wr_count, rd_last);
        end
        wq = '{8'h80};
        run(40);
        n_vec++;
        if (got_d.size() != 8) begin
            n_err++; $display("FAIL midrst_len got %0d exp 8", got_d.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                n_vec++;
                if (got_d[k] != slot_of(8'h80, k, 1, 8) || got_l[k] != int'(k == 7)) begin
                    n_err++; $display("FAIL midrst_slot%0d got d=%0d l=%0d exp d=%0d l=%0d", k, got_d[k],
                                      got_l[k], slot_of(8'h80, k, 1, 8), int'(k == 7));
                end
            end
        end
    endtask

    task automatic test_illegal;
        do_reset;
        for (int i = 0; i < 6; i++) begin
            rd_en = (i % 2 == 0);
            tick;
            n_vec++; if (rd_vld !== 1'b0 || rd_empty !== 1'b1 || wr_count !== 3'd0) begin
                n_err++; $display("FAIL idle_rd%0d got vld=%b empty=%b count=%0d exp 0/1/0",
                                  i, rd_vld, rd_empty, wr_count);
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_random;
        int exp_d[$], exp_l[$];
        int outst, sent, cyc, ed, el;
        logic [7:0] w;
        do_reset;
        outst = 0; sent = 0; cyc = 0;
        while ((sent < 40 || exp_d.size() > 0) && cyc < 4000) begin
            if (rd_vld) begin
                n_vec++;
                if (exp_d.size() == 0) begin
                    n_err++; $display("FAIL rand_extra got d=%b exp no slot", rd_data);
                end else begin
                    ed = exp_d.pop_front(); el = exp_l.pop_front();
                    if (int'(rd_data) != ed || int'(rd_last) != el) begin
                        n_err++; $display("FAIL rand_slot got d=%b l=%b exp d=%0d l=%0d cyc=%0d",
                                          rd_data, rd_last, ed, el, cyc);
                    end
                    if (el == 1) outst--;
                end
            end
            rd_en = ($urandom_range(0, 3) != 0);
            if (sent < 40 && outst < DP && $urandom_range(0, 1) == 1) begin
                w = 8'($urandom);
                wr_en = 1'b1; wr_data = w;
                for (int k = 0; k < 8; k++) begin
                    exp_d.push_back(slot_of(w, k, 1, 8)); exp_l.push_back(int'(k == 7));
                end
                outst++; sent++;
            end else wr_en = 1'b0;
            tick;
            cyc++;
        end
        wr_en = 1'b0; rd_en = 1'b0;
        n_vec++;
        if (exp_d.size() != 0) begin
            n_err++; $display("FAIL rand_timeout got %0d slots pending exp 0", exp_d.size());
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_full;
        test_quad;
        test_reset_mid;
        test_illegal;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no finish exp finish before time limit");
        $fatal(1);
    end

endmodule
